// File: rtl/pel_pool_pkg.sv
// Shared parameters, psum width rule and FSM encoding for the PEL pooling stage.
`ifndef C_LOG_2
`define C_LOG_2(n) $clog2(n)
`endif

package pel_pool_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int BLOCK_DEPTH_DEF = 32;
   localparam int NUMPEB_DEF      = 16;
   localparam int LENPSUM_DEF     = 16;

   // Two DATA_WIDTH operands per product, log2(depth) accumulation growth, two guard bits.
   function automatic int psum_width(input int data_width, input int block_depth);
      return 2 * data_width + `C_LOG_2(block_depth) + 2;
   endfunction

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      CAPT  = 3'd2,
      OUT   = 3'd3,
      FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/pel_pool_if.sv
// PEL read port and activation output stream of pel_pool.
interface pel_pool_if
   import pel_pool_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int BLOCK_DEPTH = BLOCK_DEPTH_DEF,
   parameter int NUMPEB      = NUMPEB_DEF,
   parameter int LENPSUM     = LENPSUM_DEF
);
   localparam int PSUM_WIDTH = psum_width(DATA_WIDTH, BLOCK_DEPTH);

   logic                                    POOLPEB_Rd;
   logic [`C_LOG_2(NUMPEB)-1:0]             POOLPEB_EnRd;
   logic [`C_LOG_2(LENPSUM)-1:0]            POOLPEB_AddrRd;
   logic [PSUM_WIDTH*LENPSUM-1:0]           PELPOOL_Dat;

   logic                                    out_val;
   logic                                    out_rdy;
   logic [DATA_WIDTH*LENPSUM-1:0]           out_dat;
   logic [`C_LOG_2(NUMPEB*LENPSUM)-1:0]     out_addr;

   modport master (
      output POOLPEB_Rd, POOLPEB_EnRd, POOLPEB_AddrRd,
      input  PELPOOL_Dat,
      output out_val, out_dat, out_addr,
      input  out_rdy
   );

   modport slave (
      input  POOLPEB_Rd, POOLPEB_EnRd, POOLPEB_AddrRd,
      output PELPOOL_Dat,
      input  out_val, out_dat, out_addr,
      output out_rdy
   );
endinterface

// File: rtl/pool_lane.sv
// One psum lane: ReLU, arithmetic right-shift requantisation, saturation, and 2:1 max.
module pool_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = 23
) (
   input  logic [PSUM_WIDTH-1:0] psum,
   input  logic [4:0]            shift,
   input  logic [DATA_WIDTH-1:0] hold,
   output logic [DATA_WIDTH-1:0] act,
   output logic [DATA_WIDTH-1:0] act_max
);
   localparam logic [PSUM_WIDTH-1:0] SAT = PSUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

   logic [PSUM_WIDTH-1:0] relu;
   logic [PSUM_WIDTH-1:0] q;

   // After ReLU the value is non-negative, so a logical shift equals the arithmetic one.
   always_comb begin
      relu    = psum[PSUM_WIDTH-1] ? '0 : psum;
      q       = relu >> shift;
      act     = (q > SAT) ? SAT[DATA_WIDTH-1:0] : q[DATA_WIDTH-1:0];
      act_max = (hold > act) ? hold : act;
   end
endmodule

// File: rtl/pel_pool.sv
// Post-PEL sweep: reads every PEB row, requantises each lane, optionally pools PEB pairs,
// and streams one activation row per valid/ready beat.
//
//  state | meaning
//  IDLE  | waiting for start; cfg latched and counters cleared on start
//  ISSUE | read strobe to PEL for current PEB/row
//  CAPT  | PEL data valid; hold even PEB (pooling) or load output beat
//  OUT   | beat presented until accepted, then advance iterator
//  FIN   | one-cycle done pulse
module pel_pool
   import pel_pool_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int BLOCK_DEPTH = BLOCK_DEPTH_DEF,
   parameter int NUMPEB      = NUMPEB_DEF,
   parameter int LENPSUM     = LENPSUM_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_pool_en,
   input  logic [`C_LOG_2(LENPSUM):0]    cfg_num_row,
   output logic                          busy,
   output logic                          done,
   pel_pool_if.master                    bus
);
   localparam int PSUM_WIDTH = psum_width(DATA_WIDTH, BLOCK_DEPTH);
   localparam int PW         = `C_LOG_2(NUMPEB);
   localparam int RW         = `C_LOG_2(LENPSUM);
   localparam int BW         = DATA_WIDTH * LENPSUM;

   localparam logic [RW:0]   ROW_MAX  = (RW + 1)'(LENPSUM);
   localparam logic [RW-1:0] ROW_TOP  = RW'(LENPSUM - 1);
   localparam logic [PW-1:0] PEB_LAST = PW'(NUMPEB - 1);

   state_t        state;
   logic [4:0]    shift_q;
   logic          pool_q;
   logic [RW-1:0] last_row;
   logic [RW-1:0] last_row_nxt;
   logic [PW-1:0] peb;
   logic [RW-1:0] row;
   logic [BW-1:0] hold;
   logic [BW-1:0] act_vec;
   logic [BW-1:0] max_vec;
   logic          last_beat;

   for (genvar i = 0; i < LENPSUM; i++) begin : g_lane
      pool_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .PSUM_WIDTH (PSUM_WIDTH)
      ) u_lane (
         .psum    (bus.PELPOOL_Dat[i*PSUM_WIDTH +: PSUM_WIDTH]),
         .shift   (shift_q),
         .hold    (hold[i*DATA_WIDTH +: DATA_WIDTH]),
         .act     (act_vec[i*DATA_WIDTH +: DATA_WIDTH]),
         .act_max (max_vec[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Row count 0 behaves as 1; anything above LENPSUM is clamped to the full PEB.
   always_comb begin
      last_row_nxt = '0;
      if (cfg_num_row > ROW_MAX) begin
         last_row_nxt = ROW_TOP;
      end else if (cfg_num_row != '0) begin
         last_row_nxt = RW'(cfg_num_row - 1'b1);
      end
   end

   // Pooled sweeps read PEB 2k then 2k+1, so the last beat is always on the top PEB.
   assign last_beat = (peb == PEB_LAST) && (row == last_row);

   assign bus.POOLPEB_EnRd   = peb;
   assign bus.POOLPEB_AddrRd = row;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         shift_q        <= '0;
         pool_q         <= 1'b0;
         last_row       <= '0;
         peb            <= '0;
         row            <= '0;
         hold           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         bus.POOLPEB_Rd <= 1'b0;
         bus.out_val    <= 1'b0;
         bus.out_dat    <= '0;
         bus.out_addr   <= '0;
      end else begin
         bus.POOLPEB_Rd <= 1'b0;
         done           <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_q        <= cfg_shift;
                  pool_q         <= cfg_pool_en;
                  last_row       <= last_row_nxt;
                  peb            <= '0;
                  row            <= '0;
                  bus.out_addr   <= '0;
                  busy           <= 1'b1;
                  bus.POOLPEB_Rd <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               state <= CAPT;
            end
            CAPT: begin
               if (pool_q && !peb[0]) begin
                  hold           <= act_vec;
                  peb            <= peb + 1'b1;
                  bus.POOLPEB_Rd <= 1'b1;
                  state          <= ISSUE;
               end else begin
                  bus.out_dat <= pool_q ? max_vec : act_vec;
                  bus.out_val <= 1'b1;
                  state       <= OUT;
               end
            end
            OUT: begin
               if (bus.out_rdy) begin
                  bus.out_val  <= 1'b0;
                  bus.out_addr <= bus.out_addr + 1'b1;
                  if (last_beat) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     if (row == last_row) begin
                        row <= '0;
                        peb <= peb + 1'b1;
                     end else begin
                        row <= row + 1'b1;
                        // Pooled: step back from 2k+1 to 2k for the next row of the pair.
                        if (pool_q) begin
                           peb <= peb - 1'b1;
                        end
                     end
                     bus.POOLPEB_Rd <= 1'b1;
                     state          <= ISSUE;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pel_pool.sv
// Directed bench for pel_pool: PEL row-memory responder, beat/read monitor, scenario tasks.
module tb_pel_pool;
   import pel_pool_pkg::*;

   localparam int DW  = 8;
   localparam int NP  = 16;
   localparam int NL  = 16;
   localparam int PSW = 23;
   localparam int BW  = DW * NL;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] cfg_shift;
   logic       cfg_pool_en;
   logic [4:0] cfg_num_row;
   logic       busy;
   logic       done;

   pel_pool_if bus ();

   pel_pool dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_shift   (cfg_shift),
      .cfg_pool_en (cfg_pool_en),
      .cfg_num_row (cfg_num_row),
      .busy        (busy),
      .done        (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic signed [PSW-1:0] mem [NP][NL][NL];

   // PEL model: row data appears the cycle after the strobe, a filler value otherwise.
   always @(posedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (bus.POOLPEB_Rd)
            bus.PELPOOL_Dat[l*PSW +: PSW] <= mem[bus.POOLPEB_EnRd][bus.POOLPEB_AddrRd][l];
         else
            bus.PELPOOL_Dat[l*PSW +: PSW] <= PSW'(77);
      end
   end

   int            ncyc = 0;
   int            n_beats, done_cnt, done_cyc, first_rd, first_val;
   logic [BW-1:0] bdat [256];
   logic [7:0]    baddr [256];
   int            bcyc [256];
   int            rd_peb [$];
   int            rd_row [$];
   bit            prev_stall = 1'b0;
   logic [BW-1:0] prev_dat;
   logic [7:0]    prev_addr;

   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if (bus.out_dat !== prev_dat || bus.out_addr !== prev_addr ||
                bus.POOLPEB_Rd !== 1'b0 || bus.out_val !== 1'b1) begin
               bad++;
               $display("FAIL stall_hold: dat=%h addr=%0d rd=%b val=%b, required dat=%h addr=%0d rd=0 val=1",
                        bus.out_dat, bus.out_addr, bus.POOLPEB_Rd, bus.out_val, prev_dat, prev_addr);
            end
         end
         prev_stall = bus.out_val && !bus.out_rdy;
         prev_dat   = bus.out_dat;
         prev_addr  = bus.out_addr;
         if (bus.POOLPEB_Rd) begin
            rd_peb.push_back(int'(bus.POOLPEB_EnRd));
            rd_row.push_back(int'(bus.POOLPEB_AddrRd));
            if (first_rd < 0) first_rd = ncyc;
         end
         if (bus.out_val && first_val < 0) first_val = ncyc;
         if (bus.out_val && bus.out_rdy) begin
            if (n_beats < 256) begin
               bdat[n_beats]  = bus.out_dat;
               baddr[n_beats] = bus.out_addr;
               bcyc[n_beats]  = ncyc;
            end
            n_beats++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = ncyc;
         end
      end
   end

   function automatic logic [DW-1:0] gact(input logic signed [PSW-1:0] p, input int sh);
      int r;
      r = (p < 0) ? 0 : int'(p);
      r = r >>> sh;
      if (r > 127) r = 127;
      return DW'(r);
   endfunction

   task automatic clear_log();
      n_beats = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; first_val = -1;
      rd_peb.delete();
      rd_row.delete();
   endtask

   task automatic fill_const(input int v0, input int v1, input int v2, input int v3);
      int v [4];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      for (int p = 0; p < NP; p++)
         for (int r = 0; r < NL; r++)
            for (int l = 0; l < NL; l++)
               mem[p][r][l] = PSW'(v[l % 4]);
   endtask

   task automatic start_sweep(input int sh, input bit pool, input int nr, output int t);
      @(posedge clk); #1;
      cfg_shift   = sh[4:0];
      cfg_pool_en = pool;
      cfg_num_row = nr[4:0];
      start       = 1'b1;
      t           = ncyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd, input string name);
      for (int i = 0; i < budget && done_cnt == 0; i++) begin
         @(posedge clk); #1;
         if (rnd) bus.out_rdy = ($urandom_range(0, 9) < 3);
      end
      if (done_cnt == 0) begin
         total++; bad++;
         $display("FAIL %s_timeout: no done within %0d cycles, required done", name, budget);
      end
      bus.out_rdy = 1'b1;
   endtask

   // Expected beats and read order rebuilt from the PEL memory contents.
   task automatic verify_sweep(input string name, input int sh, input bit pool, input int nr);
      int            idx, ri, exp_n;
      bit            rd_ok;
      logic [DW-1:0] a, b;
      logic [BW-1:0] ev;
      exp_n = pool ? (NP / 2) * nr : NP * nr;
      total++;
      if (n_beats != exp_n) begin
         bad++;
         $display("FAIL %s_beats: got %0d beats, required %0d", name, n_beats, exp_n);
      end
      idx = 0; ri = 0; rd_ok = 1'b1;
      for (int p = 0; p < NP; p += (pool ? 2 : 1)) begin
         for (int r = 0; r < nr; r++) begin
            for (int l = 0; l < NL; l++) begin
               a = gact(mem[p][r][l], sh);
               if (pool) begin
                  b = gact(mem[p+1][r][l], sh);
                  if (b > a) a = b;
               end
               ev[l*DW +: DW] = a;
            end
            if (idx < n_beats && idx < 256) begin
               total++;
               if (bdat[idx] !== ev || baddr[idx] !== 8'(idx)) begin
                  bad++;
                  $display("FAIL %s_beat%0d: dat=%h addr=%0d, required dat=%h addr=%0d",
                           name, idx, bdat[idx], baddr[idx], ev, idx);
               end
            end
            if (ri >= rd_peb.size() || rd_peb[ri] != p || rd_row[ri] != r) rd_ok = 1'b0;
            ri++;
            if (pool) begin
               if (ri >= rd_peb.size() || rd_peb[ri] != p + 1 || rd_row[ri] != r) rd_ok = 1'b0;
               ri++;
            end
            idx++;
         end
      end
      total++;
      if (!rd_ok || rd_peb.size() != ri) begin
         bad++;
         $display("FAIL %s_reads: %0d reads or order wrong, required %0d in sweep order", name, rd_peb.size(), ri);
      end
   endtask

   task automatic test_reset();
      int t;
      total++;
      if (bus.POOLPEB_Rd !== 1'b0 || bus.POOLPEB_EnRd !== 4'd0 || bus.POOLPEB_AddrRd !== 4'd0) begin
         bad++;
         $display("FAIL reset_rdport: rd=%b peb=%0d row=%0d, required 0 0 0", bus.POOLPEB_Rd, bus.POOLPEB_EnRd, bus.POOLPEB_AddrRd);
      end
      total++;
      if (bus.out_val !== 1'b0 || bus.out_dat !== '0 || bus.out_addr !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_out: val=%b dat=%h addr=%0d busy=%b done=%b, required all 0", bus.out_val, bus.out_dat, bus.out_addr, busy, done);
      end
      fill_const(5, -3, 200, 127);
      clear_log();
      bus.out_rdy = 1'b0;
      start_sweep(0, 1'b0, 2, t);
      repeat (8) @(posedge clk);
      #1;
      total++;
      if (bus.out_val !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL midreset_stall: val=%b busy=%b, required 1 1", bus.out_val, busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (bus.out_val !== 1'b0 || bus.out_dat !== '0 || bus.out_addr !== 8'd0 || busy !== 1'b0 ||
          bus.POOLPEB_Rd !== 1'b0 || bus.POOLPEB_EnRd !== 4'd0 || bus.POOLPEB_AddrRd !== 4'd0) begin
         bad++;
         $display("FAIL midreset_out: val=%b dat=%h addr=%0d busy=%b rd=%b, required all 0", bus.out_val, bus.out_dat, bus.out_addr, busy, bus.POOLPEB_Rd);
      end
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (done_cnt != 0 || n_beats != 0) begin
         bad++;
         $display("FAIL midreset_nodone: done=%0d beats=%0d, required 0 0", done_cnt, n_beats);
      end
      clear_log();
      bus.out_rdy = 1'b1;
      start_sweep(0, 1'b0, 1, t);
      wait_done(300, 1'b0, "restart");
      total++;
      if (rd_peb.size() == 0 || rd_peb[0] != 0 || rd_row[0] != 0 || first_rd != t + 1 || baddr[0] !== 8'd0) begin
         bad++;
         $display("FAIL restart_first: first read cycle %0d, beat0 addr %0d, required read at %0d of PEB0 row0, addr 0",
                  first_rd, baddr[0], t + 1);
      end
      verify_sweep("restart", 0, 1'b0, 1);
   endtask

   task automatic test_unpooled();
      int t;
      logic [BW-1:0] ev;
      logic [DW-1:0] e [4];
      e[0] = 8'd5; e[1] = 8'd0; e[2] = 8'd127; e[3] = 8'd127;
      for (int l = 0; l < NL; l++) ev[l*DW +: DW] = e[l % 4];
      fill_const(5, -3, 200, 127);
      clear_log();
      bus.out_rdy = 1'b1;
      start_sweep(0, 1'b0, 2, t);
      wait_done(400, 1'b0, "unpooled");
      total++;
      if (first_rd != t + 1 || first_val != t + 3) begin
         bad++;
         $display("FAIL unpooled_latency: rd at %0d val at %0d, required %0d %0d", first_rd, first_val, t + 1, t + 3);
      end
      total++;
      if (bdat[0] !== ev || bdat[31] !== ev) begin
         bad++;
         $display("FAIL unpooled_lanes: beat0=%h beat31=%h, required %h", bdat[0], bdat[31], ev);
      end
      total++;
      if (bcyc[1] - bcyc[0] != 3) begin
         bad++;
         $display("FAIL unpooled_rate: beat spacing %0d, required 3", bcyc[1] - bcyc[0]);
      end
      total++;
      if (done_cnt != 1 || done_cyc != bcyc[31] + 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL unpooled_done: count=%0d cyc=%0d busy=%b, required 1 at %0d busy 0", done_cnt, done_cyc, busy, bcyc[31] + 1);
      end
      verify_sweep("unpooled", 0, 1'b0, 2);
   endtask

   task automatic test_shift();
      int t;
      logic [BW-1:0] ev;
      int            v [8];
      int            e [8];
      v = '{2047, 1000, -1, 4194303, 2032, 2048, 15, 16};
      e = '{127, 62, 0, 127, 127, 127, 0, 1};
      ev = '0;
      for (int p = 0; p < NP; p++)
         for (int r = 0; r < NL; r++)
            for (int l = 0; l < NL; l++)
               mem[p][r][l] = (l < 8) ? PSW'(v[l]) : PSW'(0);
      for (int l = 0; l < 8; l++) ev[l*DW +: DW] = DW'(e[l]);
      clear_log();
      start_sweep(4, 1'b0, 0, t);
      wait_done(300, 1'b0, "shift");
      total++;
      if (bdat[0] !== ev || bdat[15] !== ev) begin
         bad++;
         $display("FAIL shift_lanes: beat0=%h beat15=%h, required %h", bdat[0], bdat[15], ev);
      end
      verify_sweep("shift_rows0", 4, 1'b0, 1);
   endtask

   task automatic test_pooled();
      int t;
      fill_const(0, 0, 0, 0);
      for (int k = 0; k < NP / 2; k++) begin
         mem[2*k][0][0]   = PSW'(10 + k);
         mem[2*k+1][0][0] = PSW'(5);
         mem[2*k][0][1]   = PSW'(50);
         mem[2*k+1][0][1] = PSW'(20);
      end
      mem[0][0][0] = PSW'(10);
      mem[1][0][0] = PSW'(40);
      mem[2][0][0] = PSW'(90);
      mem[3][0][0] = -PSW'(7);
      clear_log();
      start_sweep(0, 1'b1, 1, t);
      wait_done(300, 1'b0, "pooled");
      total++;
      if (bdat[0][7:0] !== 8'd40 || bdat[1][7:0] !== 8'd90 || bdat[0][15:8] !== 8'd50) begin
         bad++;
         $display("FAIL pooled_max: b0l0=%0d b1l0=%0d b0l1=%0d, required 40 90 50", bdat[0][7:0], bdat[1][7:0], bdat[0][15:8]);
      end
      total++;
      if (first_val != t + 5 || bcyc[1] - bcyc[0] != 5) begin
         bad++;
         $display("FAIL pooled_timing: val at %0d spacing %0d, required %0d and 5", first_val, bcyc[1] - bcyc[0], t + 5);
      end
      verify_sweep("pooled", 0, 1'b1, 1);
   endtask

   task automatic test_random_rdy();
      int t;
      for (int p = 0; p < NP; p++)
         for (int r = 0; r < NL; r++)
            for (int l = 0; l < NL; l++)
               mem[p][r][l] = PSW'(int'($urandom_range(0, 1200)) - 400);
      clear_log();
      bus.out_rdy = 1'b0;
      start_sweep(2, 1'b0, 16, t);
      wait_done(6000, 1'b1, "rand_unpooled");
      verify_sweep("rand_unpooled", 2, 1'b0, 16);
      clear_log();
      bus.out_rdy = 1'b0;
      start_sweep(1, 1'b1, 3, t);
      wait_done(3000, 1'b1, "rand_pooled");
      verify_sweep("rand_pooled", 1, 1'b1, 3);
   endtask

   task automatic test_start_ignored();
      int t;
      fill_const(100, 100, 100, 100);
      clear_log();
      bus.out_rdy = 1'b1;
      start_sweep(0, 1'b0, 1, t);
      repeat (10) @(posedge clk);
      #1;
      cfg_shift = 5'd3; cfg_pool_en = 1'b1; cfg_num_row = 5'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 300 && done !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL ignore_timeout: done=%b, required 1", done);
      end
      start = 1'b1;
      total++;
      if (n_beats != 16) begin
         bad++;
         $display("FAIL ignore_count: %0d beats, required 16", n_beats);
      end
      verify_sweep("ignore", 0, 1'b0, 1);
      @(posedge clk); #1;
      clear_log();
      cfg_shift = 5'd0; cfg_pool_en = 1'b1; cfg_num_row = 5'd1;
      t = ncyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL restart_after_done: busy=%b, required 1", busy);
      end
      wait_done(300, 1'b0, "after_done");
      total++;
      if (first_rd != t + 1) begin
         bad++;
         $display("FAIL after_done_first: read at %0d, required %0d", first_rd, t + 1);
      end
      verify_sweep("after_done", 0, 1'b1, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0;
      cfg_shift = '0; cfg_pool_en = 1'b0; cfg_num_row = '0;
      bus.out_rdy = 1'b0;
      clear_log();
      fill_const(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_unpooled();
      test_shift();
      test_pooled();
      test_random_rdy();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
